// File: rtl/io_timer_unit_pkg.sv
// io_timer_unit shared definitions: register offsets, control bit
// positions, per-timer write strobes and the timer state encoding.
package io_timer_unit_pkg;

    localparam logic [3:0] OFF_CTRL0   = 4'h0;
    localparam logic [3:0] OFF_RELOAD0 = 4'h1;
    localparam logic [3:0] OFF_COUNT0  = 4'h2;
    localparam logic [3:0] OFF_STAT0   = 4'h3;
    localparam logic [3:0] OFF_CTRL1   = 4'h4;
    localparam logic [3:0] OFF_RELOAD1 = 4'h5;
    localparam logic [3:0] OFF_COUNT1  = 4'h6;
    localparam logic [3:0] OFF_STAT1   = 4'h7;
    localparam logic [3:0] OFF_IN      = 4'h8;
    localparam logic [3:0] OFF_OUT     = 4'h9;
    localparam logic [3:0] OFF_PRESC0  = 4'hA;
    localparam logic [3:0] OFF_PRESC1  = 4'hB;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_EXP  = 0;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    typedef struct packed {
        logic ctrl;
        logic reload;
        logic count;
        logic stat;
        logic presc;
    } tmr_wr_t;

    function automatic logic [15:0] ctrl_word(
        input logic en,
        input logic auto_rl,
        input logic ie
    );
        ctrl_word = '0;
        ctrl_word[CTRL_EN]   = en;
        ctrl_word[CTRL_AUTO] = auto_rl;
        ctrl_word[CTRL_IE]   = ie;
    endfunction

endpackage

// File: rtl/io_timer_unit_timer.sv
// One programmable down-counting timer: prescaler, COUNT, RELOAD,
// CTRL, sticky EXP flag and its interrupt level.
module io_timer_unit_timer
    import io_timer_unit_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  tmr_wr_t     wr,
    input  logic [15:0] wdata,
    output logic [15:0] ctrl_rd,
    output logic [15:0] reload_rd,
    output logic [15:0] count_rd,
    output logic [15:0] stat_rd,
    output logic [15:0] presc_rd,
    output logic        irq
);

    tmr_state_e         state_q, state_d;
    logic               auto_q, auto_d;
    logic               ie_q, ie_d;
    logic               exp_q, exp_d;
    logic [15:0]        reload_q, reload_d;
    logic [15:0]        count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pc_q, pc_d;
    logic               tick;
    logic               expire;

    // A tick fires when the running prescaler reaches PRESC; a tick at 0 expires
    always_comb begin
        tick   = (state_q == TMR_RUN) && (pc_q == presc_q);
        expire = tick && (count_q == '0);
    end

    // Timer state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= TMR_IDLE;
        else        state_q <= state_d;
    end

    // Next state: CPU CTRL writes take priority over a one-shot expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TMR_IDLE: begin
                if (wr.ctrl && wdata[CTRL_EN]) state_d = TMR_RUN;
            end
            TMR_RUN: begin
                if (wr.ctrl) begin
                    if (!wdata[CTRL_EN]) state_d = TMR_IDLE;
                end else if (expire && !auto_q) begin
                    state_d = TMR_IDLE;
                end
            end
            default: state_d = TMR_IDLE;
        endcase
    end

    // Datapath next values: tick effects first, CPU stores override them
    always_comb begin
        auto_d   = auto_q;
        ie_d     = ie_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        count_d  = count_q;
        exp_d    = exp_q;
        pc_d     = (state_q == TMR_RUN && !tick) ? pc_q + 1'b1 : '0;
        if (tick) begin
            if (count_q != '0) count_d = count_q - 16'd1;
            else if (auto_q)   count_d = reload_q;
            else               count_d = '0;
        end
        if (wr.stat && wdata[STAT_EXP]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;
        if (wr.ctrl) begin
            auto_d = wdata[CTRL_AUTO];
            ie_d   = wdata[CTRL_IE];
        end
        if (wr.reload) reload_d = wdata;
        if (wr.count)  count_d  = wdata;
        if (wr.presc)  presc_d  = wdata[PRESC_W-1:0];
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            exp_q    <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            pc_q     <= '0;
        end else begin
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            pc_q     <= pc_d;
        end
    end

    // Register read views and the level interrupt
    always_comb begin
        ctrl_rd   = ctrl_word(state_q == TMR_RUN, auto_q, ie_q);
        reload_rd = reload_q;
        count_rd  = count_q;
        stat_rd   = '0;
        stat_rd[STAT_EXP] = exp_q;
        presc_rd  = 16'(presc_q);
        irq       = exp_q & ie_q;
    end

endmodule

// File: rtl/io_timer_unit.sv
// Memory-mapped I/O window: two timers, synchronized input port,
// output register, combinational loads and clocked stores.
module io_timer_unit
    import io_timer_unit_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'hFF00,
    parameter int          PRESC_W  = 8,
    parameter int          INT_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addresses,
    inout  wire  [15:0] data_inout,
    input  logic        oe,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] in_port,
    output logic [15:0] out_port,
    output logic [7:0]  int_req
);

    logic        sel;
    logic [3:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] rdata;
    tmr_wr_t     wr0, wr1;

    logic [15:0] sync1_q, sync1_d;
    logic [15:0] sync2_q, sync2_d;
    logic [15:0] out_q, out_d;

    logic [15:0] t0_ctrl, t0_reload, t0_count, t0_stat, t0_presc;
    logic [15:0] t1_ctrl, t1_reload, t1_count, t1_stat, t1_presc;
    logic        t0_irq, t1_irq;

    // Window decode and per-register store strobes
    always_comb begin
        sel        = (addresses[15:4] == BASE[15:4]);
        off        = addresses[3:0];
        wr_en      = we & oe & sel;
        rd_en      = re & ~oe & sel;
        wr0.ctrl   = wr_en && (off == OFF_CTRL0);
        wr0.reload = wr_en && (off == OFF_RELOAD0);
        wr0.count  = wr_en && (off == OFF_COUNT0);
        wr0.stat   = wr_en && (off == OFF_STAT0);
        wr0.presc  = wr_en && (off == OFF_PRESC0);
        wr1.ctrl   = wr_en && (off == OFF_CTRL1);
        wr1.reload = wr_en && (off == OFF_RELOAD1);
        wr1.count  = wr_en && (off == OFF_COUNT1);
        wr1.stat   = wr_en && (off == OFF_STAT1);
        wr1.presc  = wr_en && (off == OFF_PRESC1);
    end

    io_timer_unit_timer #(
        .PRESC_W (PRESC_W)
    ) u_tmr0 (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr0),
        .wdata     (data_inout),
        .ctrl_rd   (t0_ctrl),
        .reload_rd (t0_reload),
        .count_rd  (t0_count),
        .stat_rd   (t0_stat),
        .presc_rd  (t0_presc),
        .irq       (t0_irq)
    );

    io_timer_unit_timer #(
        .PRESC_W (PRESC_W)
    ) u_tmr1 (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr1),
        .wdata     (data_inout),
        .ctrl_rd   (t1_ctrl),
        .reload_rd (t1_reload),
        .count_rd  (t1_count),
        .stat_rd   (t1_stat),
        .presc_rd  (t1_presc),
        .irq       (t1_irq)
    );

    // Two-stage input synchronizer and OUT register next values
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        out_d   = out_q;
        if (wr_en && off == OFF_OUT) out_d = data_inout;
    end

    // Port registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
        end
    end

    // Load mux; reserved offsets read as zero
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL0:   rdata = t0_ctrl;
            OFF_RELOAD0: rdata = t0_reload;
            OFF_COUNT0:  rdata = t0_count;
            OFF_STAT0:   rdata = t0_stat;
            OFF_CTRL1:   rdata = t1_ctrl;
            OFF_RELOAD1: rdata = t1_reload;
            OFF_COUNT1:  rdata = t1_count;
            OFF_STAT1:   rdata = t1_stat;
            OFF_IN:      rdata = sync2_q;
            OFF_OUT:     rdata = out_q;
            OFF_PRESC0:  rdata = t0_presc;
            OFF_PRESC1:  rdata = t1_presc;
            default:     rdata = '0;
        endcase
    end

    assign data_inout = rd_en ? rdata : {16{1'bz}};

    // Output port and interrupt lines placed at INT_BASE
    always_comb begin
        out_port             = out_q;
        int_req              = '0;
        int_req[INT_BASE]    = t0_irq;
        int_req[INT_BASE+1]  = t1_irq;
    end

endmodule

// File: tb/tb_io_timer_unit.sv
// Bench for io_timer_unit: directed scenarios plus random bus traffic,
// compared every cycle against a behavioural register/timer model.
module tb_io_timer_unit;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addresses = '0;
    logic [15:0] in_port = '0;
    logic [15:0] tb_dout = '0;
    logic        oe = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        probe = 1'b0;
    wire  [15:0] data_inout;
    logic [15:0] out_port;
    logic [7:0]  int_req;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    assign data_inout = (oe || probe) ? tb_dout : {16{1'bz}};

    always #50 clk = ~clk;

    io_timer_unit #(
        .BASE     (BASE),
        .PRESC_W  (8),
        .INT_BASE (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addresses  (addresses),
        .data_inout (data_inout),
        .oe         (oe),
        .we         (we),
        .re         (re),
        .in_port    (in_port),
        .out_port   (out_port),
        .int_req    (int_req)
    );

    // behavioural model state
    logic [15:0] m_cnt [2] = '{16'd0, 16'd0};
    logic [15:0] m_rel [2] = '{16'd0, 16'd0};
    bit          m_en  [2] = '{0, 0};
    bit          m_auto[2] = '{0, 0};
    bit          m_ie  [2] = '{0, 0};
    bit          m_exp [2] = '{0, 0};
    int          m_presc[2] = '{0, 0};
    int          m_pc  [2] = '{0, 0};
    logic [15:0] m_out = '0;
    logic [15:0] m_hist[$];

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] m_in();
        return (m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 16'h0;
    endfunction

    function automatic logic [15:0] m_read(logic [3:0] o);
        int n;
        n = int'(o) / 4;
        if (o < 4'd8) begin
            case (o % 4)
                0: return {13'd0, m_ie[n], m_auto[n], m_en[n]};
                1: return m_rel[n];
                2: return m_cnt[n];
                default: return {15'd0, m_exp[n]};
            endcase
        end
        case (o)
            4'h8: return m_in();
            4'h9: return m_out;
            4'hA: return 16'(m_presc[0]);
            4'hB: return 16'(m_presc[1]);
            default: return 16'h0;
        endcase
    endfunction

    task automatic model_step();
        bit w, tick, expire;
        int o;
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                m_cnt[n] = 0; m_rel[n] = 0; m_en[n] = 0; m_auto[n] = 0;
                m_ie[n] = 0; m_exp[n] = 0; m_presc[n] = 0; m_pc[n] = 0;
            end
            m_out = 0;
            m_hist.delete();
            m_hist.push_back(16'h0);
            m_hist.push_back(16'h0);
            return;
        end
        w = we && oe && (addresses[15:4] == BASE[15:4]);
        o = int'(addresses[3:0]);
        for (int n = 0; n < 2; n++) begin
            tick   = m_en[n] && (m_pc[n] == m_presc[n]);
            expire = tick && (m_cnt[n] == 0);
            m_pc[n] = (m_en[n] && !tick) ? m_pc[n] + 1 : 0;
            if (tick)
                m_cnt[n] = (m_cnt[n] != 0) ? m_cnt[n] - 16'd1
                         : (m_auto[n] ? m_rel[n] : 16'd0);
            if (expire && !m_auto[n]) m_en[n] = 0;
            if (w && o == 4*n+3 && tb_dout[0]) m_exp[n] = 0;
            if (expire) m_exp[n] = 1;
            if (w && o == 4*n) begin
                m_en[n] = tb_dout[0]; m_auto[n] = tb_dout[1]; m_ie[n] = tb_dout[2];
            end
            if (w && o == 4*n+1) m_rel[n] = tb_dout;
            if (w && o == 4*n+2) m_cnt[n] = tb_dout;
            if (w && o == 10+n) m_presc[n] = int'(tb_dout[7:0]);
        end
        if (w && o == 9) m_out = tb_dout;
        m_hist.push_back(in_port);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endtask

    always @(posedge clk) model_step();

    // compare process: every cycle once outputs have settled
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] ereq;
            ereq = 8'(m_exp[0] & m_ie[0]) | (8'(m_exp[1] & m_ie[1]) << 1);
            chk("cyc out_port", out_port, m_out);
            chk("cyc int_req", {8'h0, int_req}, {8'h0, ereq});
            if (re && !oe && addresses[15:4] == BASE[15:4])
                chk($sformatf("cyc load @%h", addresses), data_inout,
                    m_read(addresses[3:0]));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; re = 0; oe = 0; probe = 0;
    endtask

    task automatic wr_a(logic [15:0] a, logic [15:0] d);
        addresses = a; tb_dout = d; oe = 1; we = 1; re = 0; probe = 0;
        nxt();
        idle();
    endtask

    task automatic wr(logic [3:0] o, logic [15:0] d);
        wr_a(BASE | 16'(o), d);
    endtask

    task automatic rd(logic [3:0] o, output logic [15:0] d);
        addresses = BASE | 16'(o); oe = 0; we = 0; re = 1; probe = 0;
        #1;
        d = data_inout;
    endtask

    initial begin
        logic [15:0] v;
        // reset with active store attempt and all-ones input
        reset = 0; in_port = 16'hFFFF;
        addresses = BASE | 16'h9; tb_dout = 16'hFFFF; oe = 1; we = 1;
        nxt();
        chk_en = 1;
        nxt();
        chk("rst out_port", out_port, 16'h0);
        chk("rst int_req", {8'h0, int_req}, 16'h0);
        idle();
        reset = 1;
        for (int o = 0; o < 16; o++) begin
            rd(4'(o), v);
            chk($sformatf("rst rd %0d", o), v, 16'h0);
        end
        nxt();
        rd(4'h8, v); chk("IN 1 cycle", v, 16'h0);
        nxt();
        rd(4'h8, v); chk("IN 2 cycles", v, 16'hFFFF);

        // one-shot timer 0
        wr(4'hA, 16'd0); wr(4'h2, 16'd3); wr(4'h0, 16'd5);
        rd(4'h2, v); chk("t0 cnt start", v, 16'd3);
        nxt(); rd(4'h2, v); chk("t0 cnt 2", v, 16'd2);
        nxt(); rd(4'h2, v); chk("t0 cnt 1", v, 16'd1);
        nxt(); rd(4'h2, v); chk("t0 cnt 0", v, 16'd0);
        chk("t0 irq before", {8'h0, int_req}, 16'h0);
        nxt();
        chk("t0 irq expiry", {8'h0, int_req}, 16'h1);
        rd(4'h0, v); chk("t0 ctrl EN clr", v, 16'h4);
        rd(4'h3, v); chk("t0 stat", v, 16'h1);
        wr(4'h3, 16'h1);
        chk("t0 irq cleared", {8'h0, int_req}, 16'h0);

        // auto-reload timer 1
        wr(4'hB, 16'd2); wr(4'h5, 16'd1); wr(4'h6, 16'd1); wr(4'h4, 16'd7);
        nxt(); nxt(); nxt();
        rd(4'h6, v); chk("t1 cnt tick1", v, 16'd0);
        nxt(); nxt();
        chk("t1 irq c5", {8'h0, int_req}, 16'h0);
        nxt();
        chk("t1 irq c6", {8'h0, int_req}, 16'h2);
        rd(4'h6, v); chk("t1 reload", v, 16'd1);
        rd(4'h4, v); chk("t1 still run", v, 16'h7);
        wr(4'h7, 16'h1);
        chk("t1 irq clr", {8'h0, int_req}, 16'h0);
        nxt(); nxt(); nxt(); nxt();
        chk("t1 irq c11", {8'h0, int_req}, 16'h0);
        nxt();
        chk("t1 irq c12", {8'h0, int_req}, 16'h2);
        wr(4'h4, 16'h0); wr(4'h7, 16'h1);

        // collisions on timer 0 (ticks every cycle)
        wr(4'h1, 16'd0); wr(4'h2, 16'd10); wr(4'h0, 16'd3);
        nxt();
        wr(4'h2, 16'd5);
        rd(4'h2, v); chk("coll cnt wins", v, 16'd5);
        nxt(); rd(4'h2, v); chk("coll cnt next", v, 16'd4);
        wr(4'h2, 16'd1);
        nxt();
        wr(4'h3, 16'h1);
        rd(4'h3, v); chk("coll set wins", v, 16'h1);
        wr(4'h0, 16'h0); wr(4'h3, 16'h1);
        rd(4'h3, v); chk("stat clear", v, 16'h0);

        // bus isolation
        wr(4'h9, 16'hA5A5);
        chk("out A5A5", out_port, 16'hA5A5);
        wr_a(16'hFE09, 16'h1234);
        chk("out FE09", out_port, 16'hA5A5);
        wr_a(16'hFF0E, 16'h1234);
        chk("out FF0E", out_port, 16'hA5A5);
        rd(4'hE, v); chk("rsvd rd", v, 16'h0);
        addresses = 16'hFF09; re = 1; oe = 1; we = 0; tb_dout = 16'h0;
        #1; chk("load oe=1", data_inout, 16'h0);
        idle(); probe = 1; tb_dout = 16'h0;
        #1; chk("no load re=0", data_inout, 16'h0);
        idle();
        nxt();

        // reset mid-count
        wr(4'hA, 16'd255); wr(4'h2, 16'd100); wr(4'h0, 16'd5);
        nxt();
        rd(4'h2, v); chk("pre-rst cnt", v, 16'd100);
        reset = 0;
        nxt();
        reset = 1;
        rd(4'h2, v); chk("rst cnt", v, 16'd0);
        rd(4'h0, v); chk("rst ctrl", v, 16'd0);
        chk("rst irq", {8'h0, int_req}, 16'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  o;
            logic [15:0] d;
            int          kind;
            idle();
            reset   = ($urandom_range(0, 199) != 0);
            in_port = 16'($urandom);
            o = 4'($urandom_range(0, 15));
            addresses = ($urandom_range(0, 9) == 0) ? 16'($urandom) : (BASE | 16'(o));
            case (o)
                4'h1, 4'h2, 4'h5, 4'h6: d = 16'($urandom_range(0, 6));
                4'hA, 4'hB: d = 16'($urandom_range(0, 3)) | (16'($urandom) & 16'hFF00);
                4'h0, 4'h4: d = 16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFFF8);
                default: d = 16'($urandom);
            endcase
            tb_dout = d;
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                oe = 1; we = ($urandom_range(0, 3) != 0);
            end else if (kind < 8) begin
                re = 1;
            end else if (kind == 8) begin
                re = 1; oe = 1;
            end
            nxt();
        end
        idle();
        reset = 1;
        nxt(); nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/io_timer_unit.md
Name: io_timer_unit

Overview:
Memory-mapped peripheral block that sits directly downstream of the datapath's address/data bus (addresses, data_inout, oe). It decodes a 16-word I/O window and provides two programmable down-counting timers, one synchronized input port and one output register. Timer expiry raises interrupt request lines that feed the datapath's int_e inputs. Loads are combinational so that a single-cycle load completes in the same cycle; stores commit on the clock edge.

Parameters:
BASE, 16'hFF00, base address of the 16-word window; low 4 bits must be zero
PRESC_W, 8, width of each timer's prescaler register
INT_BASE, 0, int_req bit index used by timer 0; timer 1 uses INT_BASE+1; range 0..6

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
addresses  in  16  bus address from the datapath ALU
data_inout  inout  16  shared data bus; driven here only during a decoded load
oe  in  1  1 = the datapath drives data_inout (store cycle)
we  in  1  store strobe from the control unit; a write occurs only when we=1, oe=1 and the address is decoded
re  in  1  load strobe; the bus is driven only when re=1, oe=0 and the address is decoded
in_port  in  16  asynchronous external inputs
out_port  out  16  output register
int_req  out  8  interrupt requests to int_e; only bits INT_BASE and INT_BASE+1 are used, all others 0

Behaviour:
- Select: sel = (addresses[15:4] == BASE[15:4]); offset = addresses[3:0].
- Register map, per timer n at base 4n (n = 0 or 1):
  - +0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - +1 RELOAD: 16 bits.
  - +2 COUNT: 16 bits, read/write.
  - +3 STAT: bit0 EXP; a write of 1 clears it, a write of 0 has no effect.
- Register map, ports and prescalers:
  - 0x8 IN: read-only, synchronized in_port.
  - 0x9 OUT: read/write.
  - 0xA PRESC0, 0xB PRESC1: low PRESC_W bits.
  - 0xC..0xF: reserved; loads return 16'h0000 and stores are ignored.
- Reset (reset=0 at a clk edge): every register, prescaler counter, synchronizer flop, out_port and int_req goes to 0. Reset during counting aborts immediately.
- Load timing: data_inout = selected register when re & ~oe & sel, combinational in the same cycle. Otherwise data_inout is 'z'.
- Store timing: the register updates at the clk edge where we & oe & sel. The value is visible on the following cycle.
- Input synchronizer: two flops, so IN lags in_port by 2 cycles.
- Per-timer prescaler: 8-bit counter pc, active while EN=1.
  - When pc == PRESC, a tick occurs and pc returns to 0; otherwise pc increments.
  - When EN=0, pc is held at 0.
  - PRESC=0 gives one tick per cycle.
- On a tick:
  - If COUNT != 0: COUNT decrements.
  - If COUNT == 0: EXP is set. If AUTO=1, COUNT loads RELOAD; if AUTO=0, EN clears and COUNT stays 0.
- Timer state machine per timer: IDLE (EN=0) -> RUN (EN written to 1) -> IDLE (one-shot expiry or EN written to 0). RUN remains RUN on an auto-reload expiry.
- Interrupts: int_req[INT_BASE+n] = EXP_n & IE_n. The line is a level held until software clears EXP.
- Simultaneous events:
  - A CPU write to COUNT or CTRL in the same cycle as a tick wins over the tick update.
  - An expiry in the same cycle as a STAT clear write leaves EXP = 1 (set wins).
  - Writing CTRL.EN 0->1 resets pc to 0.
- Wrap-around: COUNT never underflows below 0. RELOAD = 0 with AUTO=1 expires on every tick.
- Reserved bits in CTRL and STAT are ignored on write.

Decomposition:
- Shared package io_defs: BASE offsets (OFF_CTRL0..OFF_PRESC1), CTRL bit positions, STAT_EXP.
- One natural sub-module, io_timer: prescaler, COUNT, RELOAD, CTRL, EXP and irq for one timer. Instantiate it twice.
- Top level: address decode, read mux, tri-state driver, input synchronizer, OUT register.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_port=16'hFFFF and we=1 -> out_port=0, int_req=0, data_inout='z'. Loads of all 16 offsets after reset read 0, except IN, which reads 16'hFFFF two cycles after release.
2. One-shot timer 0: PRESC0=0, COUNT0=3, CTRL0=3'b101 -> COUNT goes 2,1,0 over 3 cycles. On the 4th tick EXP=1, int_req[0]=1 and EN=0. Storing 1 to STAT0 drops int_req[0] on the next cycle.
3. Auto-reload timer 1: PRESC1=2, RELOAD1=1, COUNT1=1, CTRL1=3'b111 -> a tick every 3 cycles. EXP sets on the 2nd tick (cycle 6) and COUNT reloads to 1. After clearing EXP it sets again at cycle 12.
4. Collisions:
   - A COUNT0=5 store on the tick cycle -> COUNT0 reads 5, not decremented.
   - A STAT clear on the expiry cycle -> EXP remains 1.
5. Bus isolation:
   - A store to 16'hFE09 or 16'hFF0E -> out_port unchanged.
   - A load with oe=1 -> data_inout not driven here.
   - A store of 16'hA5A5 to 16'hFF09 -> out_port=16'hA5A5 on the next cycle.
6. Reset mid-count: reset=0 while COUNT0=100 and RUN -> the next cycle shows COUNT0=0, EN=0 and int_req=0.
